// File: rtl/i2s_sched_pkg.sv
// i2s_sched_pkg: shared state encoding and default sizes for the I2S stereo frame scheduler.
package i2s_sched_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FRAME_DIV  = 256;
  localparam int DEF_CNT_WIDTH  = 16;
  typedef enum logic [2:0] {IDLE, GRAB_L, GRAB_R, SEND_L, SEND_R} state_e;
endpackage

// File: rtl/i2s_frame_tick.sv
// i2s_frame_tick: enable-gated reload counter emitting one tick every FRAME_DIV cycles.
module i2s_frame_tick
  import i2s_sched_pkg::*;
#(
  parameter int FRAME_DIV = DEF_FRAME_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  output logic tick_o
);
  localparam logic [15:0] RELOAD = 16'(FRAME_DIV - 1);
  logic [15:0] cnt_q, cnt_d;
  assign tick_o = enable_i && cnt_q == '0;
  // Held at reload while disabled so a re-enable always waits a full frame period.
  always_comb cnt_d = (!enable_i || tick_o) ? RELOAD : cnt_q - 16'd1;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= RELOAD;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/i2s_tx_stereo_sched.sv
// i2s_tx_stereo_sched: merges left/right mono streams into a tick-paced L/R word stream
// with underrun substitution and late-frame detection.
module i2s_tx_stereo_sched
  import i2s_sched_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int FRAME_DIV        = DEF_FRAME_DIV,
  parameter int HOLD_ON_UNDERRUN = 0,
  parameter int CNT_WIDTH        = DEF_CNT_WIDTH
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_aresetn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_l_tdata,
  input  logic                  s_l_tvalid,
  output logic                  s_l_tready,
  input  logic [DATA_WIDTH-1:0] s_r_tdata,
  input  logic                  s_r_tvalid,
  output logic                  s_r_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  clr_status,
  output logic [CNT_WIDTH-1:0]  underrun_cnt,
  output logic                  late_frame
);
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] l_q, l_d, r_q, r_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  late_q, late_d;
  logic                  tick, underrun;
  i2s_frame_tick #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk_i   (s00_axis_aclk),
    .rst_ni  (s00_axis_aresetn),
    .enable_i(enable),
    .tick_o  (tick)
  );
  assign s_l_tready    = state_q == GRAB_L;
  assign s_r_tready    = state_q == GRAB_R;
  assign m_axis_tvalid = state_q == SEND_L || state_q == SEND_R;
  assign m_axis_tlast  = state_q == SEND_R;
  assign m_axis_tdata  = state_q == SEND_L ? l_q : state_q == SEND_R ? r_q : '0;
  assign underrun_cnt  = cnt_q;
  assign late_frame    = late_q;
  assign underrun      = (s_l_tready && !s_l_tvalid) || (s_r_tready && !s_r_tvalid);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = tick ? GRAB_L : IDLE;
      GRAB_L:  state_d = GRAB_R;
      GRAB_R:  state_d = SEND_L;
      SEND_L:  state_d = m_axis_tready ? SEND_R : SEND_L;
      SEND_R:  state_d = m_axis_tready ? IDLE : SEND_R;
      default: state_d = IDLE;
    endcase
  end
  // An underrun either zeroes the slot or keeps the previous good sample.
  always_comb begin
    l_d = l_q;
    r_d = r_q;
    if (s_l_tready) l_d = s_l_tvalid ? s_l_tdata : (HOLD_ON_UNDERRUN != 0 ? l_q : '0);
    if (s_r_tready) r_d = s_r_tvalid ? s_r_tdata : (HOLD_ON_UNDERRUN != 0 ? r_q : '0);
  end
  always_comb begin
    cnt_d  = clr_status ? '0 : (underrun && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    late_d = clr_status ? 1'b0 : late_q || (tick && state_q != IDLE);
  end
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn)
    if (!s00_axis_aresetn) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      late_q  <= late_d;
    end
endmodule
